// File: rtl/level_meter_ctrl_pkg.sv
// Shared types, constants and helpers for the channel-strip level meter.
// Provides the sample type, meter mode and FSM state encodings, the
// per-mille full-scale constant, and small arithmetic helpers:
//   sample_mag  : |x| of a signed sample, saturating -32768 to 32767
//   to_permille : 15-bit peak magnitude scaled to 0..999 per-mille
//   bcd_adjust  : double-dabble add-3 correction on three BCD digits
package channel_strip_pkg;

   typedef logic signed [15:0] sample_t;
   typedef logic [3:0]         bcd_t;

   typedef enum logic [1:0] {
      MTR_IN   = 2'd0,
      MTR_OUT  = 2'd1,
      MTR_GAIN = 2'd2
   } meter_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCALE   = 2'd1,
      ST_CONVERT = 2'd2,
      ST_DONE    = 2'd3
   } meter_state_e;

   localparam int PERMILLE_FS = 1000;

   // The most negative code has no positive twin in 16 bits, so it clips.
   function automatic logic [14:0] sample_mag(input sample_t x);
      logic [14:0] m;
      if (x == 16'sh8000) begin
         m = 15'h7FFF;
      end else if (x[15]) begin
         m = 15'(-x);
      end else begin
         m = x[14:0];
      end
      return m;
   endfunction

   // (peak * 1000) >> 15 in a 25-bit product; 32767 maps to 999.
   function automatic logic [9:0] to_permille(input logic [14:0] pk);
      return 10'((25'(pk) * 25'(PERMILLE_FS)) >> 5'd15);
   endfunction

   // Add 3 to every digit that is 5 or more before the next left shift.
   function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (r[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
         end else begin
            r[i*4 +: 4] = r[i*4 +: 4];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/level_meter_ctrl_if.sv
// Sample/display bundle of the level meter.
//   sample_en, in_sample, out_sample, mode : from the audio path to the meter
//   num2, num1, num0, neg, level_valid     : from the meter to the display
// master = audio path / display side, slave = the meter itself.
interface level_meter_ctrl_if;
   import channel_strip_pkg::*;

   logic       sample_en;
   sample_t    in_sample;
   sample_t    out_sample;
   logic [1:0] mode;
   bcd_t       num2;
   bcd_t       num1;
   bcd_t       num0;
   logic       neg;
   logic       level_valid;

   modport master (
      output sample_en, in_sample, out_sample, mode,
      input  num2, num1, num0, neg, level_valid
   );

   modport slave (
      input  sample_en, in_sample, out_sample, mode,
      output num2, num1, num0, neg, level_valid
   );
endinterface

// File: rtl/level_meter_ctrl_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load bin and begin a 10-iteration conversion
//   bin[9:0]   : binary value, 0..999
//   busy       : conversion in progress
//   done       : high in the cycle whose closing edge performs the last iteration
//   bcd2..bcd0 : hundreds/tens/units; only final once busy has dropped
module bin2bcd_seq
   import channel_strip_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] bin,
   output logic       busy,
   output logic       done,
   output bcd_t       bcd2,
   output bcd_t       bcd1,
   output bcd_t       bcd0
);

   logic [9:0]  bin_r;
   logic [11:0] bcd_r;
   logic [3:0]  iter_r;
   logic        busy_r;
   logic [21:0] shifted_s;

   // Correct digits, then shift the whole BCD:binary register left by one.
   assign shifted_s = {bcd_adjust(bcd_r), bin_r} << 5'd1;

   // Load on start, then run one shift/add-3 step per cycle until iter hits 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_r  <= 10'd0;
         bcd_r  <= 12'd0;
         iter_r <= 4'd0;
         busy_r <= 1'b0;
      end else if (start) begin
         bin_r  <= bin;
         bcd_r  <= 12'd0;
         iter_r <= 4'd10;
         busy_r <= 1'b1;
      end else if (busy_r) begin
         {bcd_r, bin_r} <= shifted_s;
         iter_r         <= iter_r - 4'd1;
         busy_r         <= (iter_r != 4'd1);
      end else begin
         bin_r  <= bin_r;
         bcd_r  <= bcd_r;
         iter_r <= iter_r;
         busy_r <= busy_r;
      end
   end

   assign busy = busy_r;
   assign done = busy_r && (iter_r == 4'd1);
   assign bcd2 = bcd_r[11:8];
   assign bcd1 = bcd_r[7:4];
   assign bcd0 = bcd_r[3:0];

endmodule

// File: rtl/level_meter_ctrl.sv
// Level display sequencer for a channel strip.
// Tracks peak |in| and |out| over WINDOW qualified samples, snapshots them at
// window end, scales the chosen quantity to per-mille, converts it to BCD and
// presents three digits plus a sign for one update pulse.
// Ports:
//   clk   : sample-domain clock
//   reset : asynchronous active-high reset
//   mtr   : slave side of level_meter_ctrl_if (samples/mode in, digits out)
module level_meter_ctrl
   import channel_strip_pkg::*;
#(
   parameter int unsigned WINDOW = 2400,
   parameter int unsigned SW     = 16
) (
   input  logic               clk,
   input  logic               reset,
   level_meter_ctrl_if.slave  mtr
);

   logic [15:0]   count_r;
   logic [SW-2:0] peak_in_r, peak_out_r, snap_in_r, snap_out_r;
   logic [SW-2:0] mag_in_s, mag_out_s, pk_in_next_s, pk_out_next_s;
   logic          first_s, final_s;
   meter_mode_e   mode_r;
   meter_state_e  state_r, state_next_s;
   logic          start_s, busy_s, done_s;
   logic [9:0]    pm_in_s, pm_out_s, disp_mag_s;
   logic signed [10:0] diff_s;
   logic          neg_calc_s, neg_pend_r;
   bcd_t          bcd2_s, bcd1_s, bcd0_s;
   bcd_t          num2_r, num1_r, num0_r;
   logic          neg_r, valid_r;

   // Per-sample magnitudes and running-peak candidates (first sample overwrites).
   always_comb begin
      mag_in_s  = sample_mag(mtr.in_sample);
      mag_out_s = sample_mag(mtr.out_sample);
      first_s   = (count_r == 16'd0);
      final_s   = mtr.sample_en && (count_r == 16'(WINDOW - 1));
      if (first_s || (mag_in_s > peak_in_r)) begin
         pk_in_next_s = mag_in_s;
      end else begin
         pk_in_next_s = peak_in_r;
      end
      if (first_s || (mag_out_s > peak_out_r)) begin
         pk_out_next_s = mag_out_s;
      end else begin
         pk_out_next_s = peak_out_r;
      end
   end

   // Window counter and running peaks advance only on qualified samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r    <= 16'd0;
         peak_in_r  <= '0;
         peak_out_r <= '0;
      end else if (mtr.sample_en) begin
         count_r    <= final_s ? 16'd0 : (count_r + 16'd1);
         peak_in_r  <= pk_in_next_s;
         peak_out_r <= pk_out_next_s;
      end else begin
         count_r    <= count_r;
         peak_in_r  <= peak_in_r;
         peak_out_r <= peak_out_r;
      end
   end

   // Snapshot peaks and mode at window end; a busy converter drops the snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_in_r  <= '0;
         snap_out_r <= '0;
         mode_r     <= MTR_IN;
      end else if (final_s && (state_r == ST_IDLE)) begin
         snap_in_r  <= pk_in_next_s;
         snap_out_r <= pk_out_next_s;
         mode_r     <= (mtr.mode == 2'd3) ? MTR_IN : meter_mode_e'(mtr.mode);
      end else begin
         snap_in_r  <= snap_in_r;
         snap_out_r <= snap_out_r;
         mode_r     <= mode_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next state; the converter is kicked off from SCALE.
   always_comb begin
      state_next_s = state_r;
      start_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (final_s) begin
               state_next_s = ST_SCALE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SCALE: begin
            start_s      = 1'b1;
            state_next_s = ST_CONVERT;
         end
         ST_CONVERT: begin
            if (done_s) begin
               state_next_s = ST_DONE;
            end else if (!busy_s) begin
               // Converter lost its job: recover rather than wait forever.
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_CONVERT;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Per-mille scaling and the signed gain difference for mode 2.
   always_comb begin
      pm_in_s    = to_permille(snap_in_r);
      pm_out_s   = to_permille(snap_out_r);
      diff_s     = $signed({1'b0, pm_out_s}) - $signed({1'b0, pm_in_s});
      neg_calc_s = 1'b0;
      disp_mag_s = pm_in_s;
      case (mode_r)
         MTR_OUT: begin
            disp_mag_s = pm_out_s;
         end
         MTR_GAIN: begin
            neg_calc_s = diff_s[10];
            if (diff_s[10]) begin
               disp_mag_s = 10'(-diff_s);
            end else begin
               disp_mag_s = diff_s[9:0];
            end
         end
         default: begin
            disp_mag_s = pm_in_s;
         end
      endcase
   end

   // Sign is captured alongside the converter start and shown with the digits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_pend_r <= 1'b0;
      end else if (state_r == ST_SCALE) begin
         neg_pend_r <= neg_calc_s;
      end else begin
         neg_pend_r <= neg_pend_r;
      end
   end

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst   (reset),
      .start (start_s),
      .bin   (disp_mag_s),
      .busy  (busy_s),
      .done  (done_s),
      .bcd2  (bcd2_s),
      .bcd1  (bcd1_s),
      .bcd0  (bcd0_s)
   );

   // Display registers load all at once so partial digits are never seen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num2_r  <= 4'd0;
         num1_r  <= 4'd0;
         num0_r  <= 4'd0;
         neg_r   <= 1'b0;
         valid_r <= 1'b0;
      end else if (state_r == ST_DONE) begin
         num2_r  <= bcd2_s;
         num1_r  <= bcd1_s;
         num0_r  <= bcd0_s;
         neg_r   <= neg_pend_r;
         valid_r <= 1'b1;
      end else begin
         num2_r  <= num2_r;
         num1_r  <= num1_r;
         num0_r  <= num0_r;
         neg_r   <= neg_r;
         valid_r <= 1'b0;
      end
   end

   assign mtr.num2        = num2_r;
   assign mtr.num1        = num1_r;
   assign mtr.num0        = num0_r;
   assign mtr.neg         = neg_r;
   assign mtr.level_valid = valid_r;

endmodule

// File: tb/tb_level_meter_ctrl.sv
// Self-checking bench for level_meter_ctrl with WINDOW=16.
// A window-level model (peak = max |x| over the window's samples, per-mille by
// integer division, digits by /100, /10, %10) predicts each display update
// and the cycle it must appear on; every cycle the pulse and held digits are checked.
module tb_level_meter_ctrl;
   import channel_strip_pkg::*;

   localparam int W = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   level_meter_ctrl_if mtr ();

   level_meter_ctrl #(.WINDOW(W), .SW(16)) dut (
      .clk   (clk),
      .reset (reset),
      .mtr   (mtr.slave)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int win_cnt = 0;
   int pk_in = 0;
   int pk_out = 0;
   int exp_cyc = -1;
   int busy_end = -100;
   int c0;
   logic [12:0] exp_disp = 13'd0;
   logic [12:0] held_disp = 13'd0;
   int pulse_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int mag(input int x);
      int m;
      m = (x < 0) ? -x : x;
      if (m > 32767) m = 32767;
      return m;
   endfunction

   function automatic int rnd_s();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   // {hundreds, tens, units, neg} expected for a finished window.
   function automatic logic [12:0] expect_disp(input int md, input int pi, input int po);
      int pmi, pmo, d, v;
      logic ng;
      pmi = (pi * 1000) / 32768;
      pmo = (po * 1000) / 32768;
      ng  = 1'b0;
      if (md == 1) begin
         v = pmo;
      end else if (md == 2) begin
         d  = pmo - pmi;
         ng = (d < 0);
         v  = ng ? -d : d;
      end else begin
         v = pmi;
      end
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), ng};
   endfunction

   // One clock: drive at negedge, update the model at posedge, check 1 ns later.
   task automatic step(input bit en, input int si, input int so, input int md);
      int mi, mo;
      @(negedge clk);
      mtr.sample_en  = en;
      mtr.in_sample  = 16'(si);
      mtr.out_sample = 16'(so);
      mtr.mode       = 2'(md);
      @(posedge clk);
      cyc++;
      if (en) begin
         mi = mag(si);
         mo = mag(so);
         if (win_cnt == 0) begin
            pk_in  = mi;
            pk_out = mo;
         end else begin
            if (mi > pk_in) pk_in = mi;
            if (mo > pk_out) pk_out = mo;
         end
         if (win_cnt == W - 1) begin
            win_cnt = 0;
            if (cyc > busy_end) begin
               exp_disp = expect_disp(md, pk_in, pk_out);
               exp_cyc  = cyc + 12;
               busy_end = cyc + 12;
            end
         end else begin
            win_cnt++;
         end
      end
      #1;
      if (cyc == exp_cyc) begin
         chk("level_valid_pulse", mtr.level_valid, 1);
         held_disp = exp_disp;
      end else begin
         chk("level_valid_idle", mtr.level_valid, 0);
      end
      chk("display", {mtr.num2, mtr.num1, mtr.num0, mtr.neg}, held_disp);
      if (mtr.level_valid === 1'b1) pulse_q.push_back(cyc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      mtr.sample_en = 1'b0;
      reset = 1'b1;
      #1;
      chk("reset_valid", mtr.level_valid, 0);
      chk("reset_display", {mtr.num2, mtr.num1, mtr.num0, mtr.neg}, 0);
      win_cnt = 0; pk_in = 0; pk_out = 0;
      exp_cyc = -1; busy_end = -100; held_disp = 13'd0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 14; i++) step(1'b0, 0, 0, 0);
   endtask

   initial begin
      mtr.sample_en  = 1'b0;
      mtr.in_sample  = 16'd0;
      mtr.out_sample = 16'd0;
      mtr.mode       = 2'd0;
      do_reset();

      // Constant half-scale input level: 5,0,0 twelve edges after window end.
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < W; i++) step(1'b1, 16384, rnd_s(), 0);

      // Gain mode both directions: 2,5,0 negative then positive.
      for (int i = 0; i < W; i++) step(1'b1, 16384, 8192, 2);
      for (int i = 0; i < W; i++) step(1'b1, 8192, 16384, 2);

      // Output level with saturating -32768, then silence.
      for (int i = 0; i < W; i++) step(1'b1, rnd_s(), (i % 2 == 0) ? -32768 : 100, 1);
      for (int i = 0; i < W; i++) step(1'b1, rnd_s(), 0, 1);

      // Single spike at window index 0, then a silent window.
      for (int i = 0; i < W; i++) step(1'b1, (i == 0) ? 32767 : 0, rnd_s(), 0);
      for (int i = 0; i < W; i++) step(1'b1, 0, rnd_s(), 0);
      drain();

      // Sparse sample_en (1 of 3) with a mid-window mode switch.
      for (int k = 0; k < 3 * 3 * W; k++)
         step(k % 3 == 0, rnd_s(), rnd_s(), (k < 70) ? 0 : 1);
      for (int i = 0; i < 15; i++) step(1'b0, 0, 0, 1);
      chk("update_spacing", pulse_q[$] - pulse_q[$-1], 3 * W);

      // Random samples, modes (incl. reserved 3) and qualifier.
      for (int k = 0; k < 240; k++)
         step($urandom_range(0, 3) != 0, rnd_s(), rnd_s(), int'($urandom_range(0, 3)));
      drain();

      // Reset during conversion: immediate clear, no pulse, fresh window after.
      for (int i = 0; i < W; i++) begin
         step(1'b1, 32767, rnd_s(), 0);
         if (win_cnt == 0) break;
      end
      for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 0);
      do_reset();
      c0 = cyc;
      for (int i = 0; i < W; i++) step(1'b1, 16384, 0, 0);
      drain();
      chk("first_update_after_reset", pulse_q[$], c0 + W + 12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
